hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_pkg.sv | 14 +
 rtl/hazard_control_unit_compare.sv | 12 +
 rtl/hazard_control_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared pipeline types and defaults for the hazard control unit.
package hazard_control_unit_pkg;
  localparam int REG_W = 5;
  localparam int BUB_W = 2;
  localparam int WAIT_W = 8;
  localparam int SC_W = 16;
  localparam int DEF_LOAD_USE_STALLS = 1;
  localparam int DEF_MEM_TIMEOUT = 64;
  typedef enum logic [1:0] {
    RUN,
    LOADUSE,
    MEMWAIT
  } hcu_state_e;
endpackage

// File: rtl/hazard_control_unit_compare.sv
// hazard_compare: flags a load in EX whose nonzero destination matches one ID source register.
module hazard_compare
  import hazard_control_unit_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_reg_i,
  input  logic             id_uses_i,
  output logic             hit_o
);
  assign hit_o = ex_mem_read_i && id_uses_i && (ex_rt_i != '0) && (ex_rt_i == id_reg_i);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control for load-use, taken branches and slow data memory.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int LOAD_USE_STALLS = DEF_LOAD_USE_STALLS,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemAccess,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic [SC_W-1:0]  stall_count,
  output logic             mem_error
);
  hcu_state_e state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic err_q, err_d;
  logic hit_rs, hit_rt, load_use, mem_stall, timeout, freeze, stall;

  hazard_compare u_cmp_rs (
    .ex_mem_read_i(EX_MemRead),
    .ex_rt_i      (EX_rt),
    .id_reg_i     (ID_rs),
    .id_uses_i    (1'b1),
    .hit_o        (hit_rs)
  );

  hazard_compare u_cmp_rt (
    .ex_mem_read_i(EX_MemRead),
    .ex_rt_i      (EX_rt),
    .id_reg_i     (ID_rt),
    .id_uses_i    (ID_UsesRt),
    .hit_o        (hit_rt)
  );

  assign load_use = hit_rs || hit_rt;
  assign mem_stall = MEM_MemAccess && !mem_ack;
  assign timeout = wait_q == WAIT_W'(MEM_TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    bub_d = bub_q;
    wait_d = wait_q;
    err_d = err_q;
    freeze = 1'b0;
    PC_Write = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Bubble = 1'b0;
    EXMEM_Write = 1'b1;
    MEMWB_Bubble = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      RUN: begin
        mem_req = MEM_MemAccess;
        if (mem_stall) begin
          freeze = 1'b1;
          state_d = MEMWAIT;
          wait_d = '0;
        end else if (EX_BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Bubble = 1'b1;
        end else if (load_use) begin
          PC_Write = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Bubble = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            bub_d = BUB_W'(LOAD_USE_STALLS - 1);
            state_d = LOADUSE;
          end
        end
      end
      LOADUSE: begin
        mem_req = MEM_MemAccess;
        if (mem_stall) begin
          freeze = 1'b1;
          state_d = MEMWAIT;
          wait_d = '0;
          bub_d = '0;
        end else begin
          PC_Write = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Bubble = 1'b1;
          bub_d = bub_q - 1'b1;
          state_d = (bub_q <= BUB_W'(1)) ? RUN : LOADUSE;
        end
      end
      MEMWAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = RUN;
        end else if (timeout) begin
          // give up: flag the error and let the pipeline move on without the access
          mem_req = 1'b0;
          err_d = 1'b1;
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (freeze) begin
      PC_Write = 1'b0;
      IFID_Write = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Bubble = 1'b1;
    end
    if (!rst_n) begin
      PC_Write = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b0;
      IDEX_Bubble = 1'b1;
      EXMEM_Write = 1'b0;
      MEMWB_Bubble = 1'b1;
      mem_req = 1'b0;
    end
  end

  assign stall = !PC_Write || IFID_Flush;
  assign sc_d = (stall && sc_q != '1) ? sc_q + 1'b1 : sc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      bub_q <= '0;
      wait_q <= '0;
      sc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q <= bub_d;
      wait_q <= wait_d;
      sc_q <= sc_d;
      err_q <= err_d;
    end
  end

  assign stall_count = sc_q;
  assign mem_error = err_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors with queued expectations, checked by a separate monitor.
module tb_hazard_control_unit;
  localparam logic [7:0] RUN_O = 8'hC8;
  localparam logic [7:0] ERR_O = 8'hC9;
  localparam logic [7:0] LU_O = 8'h18;
  localparam logic [7:0] BR_O = 8'hF8;
  localparam logic [7:0] FRZ_O = 8'h06;
  localparam logic [7:0] RST_O = 8'h14;
  localparam logic [7:0] REL_O = 8'hCA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_br = 1'b0, mem_acc = 1'b0, mem_ack = 1'b0;
  logic req1, pcw1, ifw1, fl1, idb1, exw1, mwb1, err1;
  logic req2, pcw2, ifw2, fl2, idb2, exw2, mwb2, err2;
  logic [15:0] sc1, sc2;
  logic [40:0] exp_q[$];
  string nm_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_dut1 (
    .clk(clk), .rst_n(rst_n), .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(id_uses_rt),
    .EX_MemRead(ex_mem_read), .EX_rt(ex_rt), .EX_BranchTaken(ex_br), .MEM_MemAccess(mem_acc),
    .mem_req(req1), .mem_ack(mem_ack), .PC_Write(pcw1), .IFID_Write(ifw1), .IFID_Flush(fl1),
    .IDEX_Bubble(idb1), .EXMEM_Write(exw1), .MEMWB_Bubble(mwb1), .stall_count(sc1), .mem_error(err1)
  );

  hazard_control_unit #(.LOAD_USE_STALLS(2), .MEM_TIMEOUT(64)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(id_uses_rt),
    .EX_MemRead(ex_mem_read), .EX_rt(ex_rt), .EX_BranchTaken(ex_br), .MEM_MemAccess(mem_acc),
    .mem_req(req2), .mem_ack(mem_ack), .PC_Write(pcw2), .IFID_Write(ifw2), .IFID_Flush(fl2),
    .IDEX_Bubble(idb2), .EXMEM_Write(exw2), .MEMWB_Bubble(mwb2), .stall_count(sc2), .mem_error(err2)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [40:0] e, g;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      g = {pcw1, ifw1, fl1, idb1, exw1, mwb1, req1, err1, sc1, pcw2, sc2};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s got=%h exp=%h (outs8,sc1,pc2,sc2)", n, g, e);
      end
    end
  end

  task automatic v(input logic rn, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                   input logic mr, input logic [4:0] xrt, input logic br, input logic ma,
                   input logic ak, input logic [7:0] eo, input logic [15:0] esc,
                   input logic epc2, input logic [15:0] esc2, input string nm);
    @(posedge clk);
    #1;
    rst_n = rn;
    id_rs = rs;
    id_rt = rt;
    id_uses_rt = ur;
    ex_mem_read = mr;
    ex_rt = xrt;
    ex_br = br;
    mem_acc = ma;
    mem_ack = ak;
    exp_q.push_back({eo, esc, epc2, esc2});
    nm_q.push_back(nm);
  endtask

  task automatic idle(input logic [7:0] eo, input logic [15:0] esc, input logic epc2,
                      input logic [15:0] esc2, input string nm);
    v(1, 1, 2, 1, 0, 0, 0, 0, 0, eo, esc, epc2, esc2, nm);
  endtask

  task automatic lu(input logic [7:0] eo, input logic [15:0] esc, input logic epc2,
                    input logic [15:0] esc2, input string nm);
    v(1, 5, 2, 1, 1, 5, 0, 0, 0, eo, esc, epc2, esc2, nm);
  endtask

  initial begin
    v(0, 1, 2, 1, 0, 0, 0, 0, 0, RST_O, 0, 0, 0, "rst_a");
    v(0, 1, 2, 1, 0, 0, 0, 0, 0, RST_O, 0, 0, 0, "rst_b");
    idle(RUN_O, 0, 1, 0, "idle0");
    lu(LU_O, 0, 0, 0, "lu1");
    idle(RUN_O, 1, 0, 1, "lu_after");
    idle(RUN_O, 1, 1, 2, "lu_done");
    v(1, 1, 7, 1, 1, 7, 0, 0, 0, LU_O, 1, 0, 2, "lu_rt");
    idle(RUN_O, 2, 0, 3, "lu_rt_after");
    idle(RUN_O, 2, 1, 4, "lu_rt_done");
    v(1, 0, 3, 1, 1, 0, 0, 0, 0, RUN_O, 2, 1, 4, "rt_zero");
    v(1, 1, 9, 0, 1, 9, 0, 0, 0, RUN_O, 2, 1, 4, "no_uses_rt");
    v(1, 4, 2, 1, 0, 4, 0, 0, 0, RUN_O, 2, 1, 4, "no_load");
    v(1, 5, 2, 1, 1, 5, 1, 0, 0, BR_O, 2, 1, 4, "br_over_lu");
    idle(RUN_O, 3, 1, 5, "br_idle");
    v(1, 1, 2, 1, 0, 0, 1, 1, 0, FRZ_O, 3, 0, 5, "frz0");
    v(1, 1, 2, 1, 0, 0, 1, 1, 0, FRZ_O, 4, 0, 6, "frz1");
    v(1, 1, 2, 1, 0, 0, 1, 1, 0, FRZ_O, 5, 0, 7, "frz2");
    v(1, 1, 2, 1, 0, 0, 1, 1, 1, REL_O, 6, 1, 8, "ack_release");
    v(1, 1, 2, 1, 0, 0, 1, 0, 0, BR_O, 6, 1, 8, "br_after");
    idle(RUN_O, 7, 1, 9, "br_once");
    lu(LU_O, 7, 0, 9, "lu2");
    v(1, 1, 2, 1, 0, 0, 0, 1, 0, FRZ_O, 8, 0, 10, "lu_mem");
    v(1, 1, 2, 1, 0, 0, 0, 1, 1, REL_O, 9, 1, 11, "lu_mem_rel");
    idle(RUN_O, 9, 1, 11, "bubbles_dropped");
    v(1, 1, 2, 1, 0, 0, 0, 1, 1, REL_O, 9, 1, 11, "mem_hit");
    v(1, 1, 2, 1, 0, 0, 0, 1, 0, FRZ_O, 9, 0, 11, "frz_a");
    v(1, 1, 2, 1, 0, 0, 0, 1, 0, FRZ_O, 10, 0, 12, "frz_b");
    v(0, 1, 2, 1, 0, 0, 0, 1, 0, RST_O, 0, 0, 0, "rst_mid_wait");
    lu(LU_O, 0, 0, 0, "post_rst_lu");
    idle(RUN_O, 1, 0, 1, "post_rst_a");
    idle(RUN_O, 1, 1, 2, "post_rst_b");
    lu(LU_O, 1, 0, 2, "lu3");
    v(0, 1, 2, 1, 0, 0, 0, 0, 0, RST_O, 0, 0, 0, "rst_mid_lu");
    idle(RUN_O, 0, 1, 0, "after_rst_lu");
    v(1, 1, 2, 1, 0, 0, 0, 1, 0, FRZ_O, 0, 0, 0, "to_enter");
    for (int i = 1; i < 64; i++) v(1, 1, 2, 1, 0, 0, 0, 1, 0, FRZ_O, 16'(i), 0, 16'(i), "to_wait");
    v(1, 1, 2, 1, 0, 0, 0, 1, 0, RUN_O, 64, 1, 64, "timeout");
    idle(ERR_O, 64, 1, 64, "err_set");
    idle(ERR_O, 64, 1, 64, "err_sticky");
    v(0, 1, 2, 1, 0, 0, 0, 0, 0, RST_O, 0, 0, 0, "rst_err");
    idle(RUN_O, 0, 1, 0, "err_clr");
    for (int i = 0; i < 65540; i++) lu(LU_O, 16'(i > 65535 ? 65535 : i), 0, 16'(i > 65535 ? 65535 : i), "sat");
    idle(RUN_O, 16'hFFFF, 1, 16'hFFFF, "sat_hold");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
